// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller: latches source edges as pending and presents the
// lowest-index unmasked one to the CPU. Define INTERRUPT_CONTROLLER_SYNC_EN for 2-flop input sync.

module interrupt_controller_src (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic clr,
  output logic pending,
  output logic overrun
);
  logic cur, prev, rise;

`ifdef INTERRUPT_CONTROLLER_SYNC_EN
  logic meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      cur  <= 1'b0;
    end else begin
      meta <= src;
      cur  <= meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) cur <= 1'b0;
    else     cur <= src;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= cur;
  end

  assign rise = cur & ~prev;
  // A new edge landing on the same cycle as its ack is a fresh request, not an overrun.
  assign overrun = rise & pending & ~clr;

  always_ff @(posedge clk) begin
    if (rst)       pending <= 1'b0;
    else if (rise) pending <= 1'b1;
    else if (clr)  pending <= 1'b0;
  end
endmodule

module interrupt_controller #(
  parameter int NUM_SRC = 4,
  parameter int NUM_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               irq_global_en,
  output logic               irq_en,
  output logic [NUM_W-1:0]   irq_num,
  input  logic               irq_ack,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               irq_overrun,
  input  logic               overrun_clr
);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] clr, ovr_evt, qual, num_oh;
  logic               win_vld, ack_fire, num_live;
  logic [NUM_W-1:0]   win_num;

  interrupt_controller_src u_src [NUM_SRC-1:0] (
    .clk     (clk),
    .rst     (rst),
    .src     (irq_src),
    .clr     (clr),
    .pending (irq_pending),
    .overrun (ovr_evt)
  );

  assign qual = irq_pending & irq_mask & {NUM_SRC{irq_global_en}};

  // Lowest index wins: scan from the top so lower indices overwrite.
  always_comb begin
    win_vld = 1'b0;
    win_num = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (qual[i]) begin
        win_vld = 1'b1;
        win_num = NUM_W'(i);
      end
    end
  end

  always_comb begin
    num_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) num_oh[i] = (irq_num == NUM_W'(i));
  end

  assign ack_fire = (state == S_ASSERT) && irq_ack;
  assign clr      = ack_fire ? num_oh : '0;
  assign num_live = irq_global_en && |(num_oh & irq_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      irq_en  <= 1'b0;
      irq_num <= '0;
    end else begin
      case (state)
        S_IDLE: if (win_vld) begin
          irq_num <= win_num;
          irq_en  <= 1'b1;
          state   <= S_ASSERT;
        end
        S_ASSERT: if (irq_ack) begin
          irq_en <= 1'b0;
          state  <= S_GAP;
        end else if (!num_live) begin
          irq_en <= 1'b0;
          state  <= S_IDLE;
        end
        S_GAP: if (!irq_ack) state <= S_IDLE;
        default: begin
          irq_en <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             irq_overrun <= 1'b0;
    else if (|ovr_evt)   irq_overrun <= 1'b1;
    else if (overrun_clr) irq_overrun <= 1'b0;
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expected request order is queued when sources
// are pulsed and checked as each request appears on irq_en/irq_num.

module tb_interrupt_controller;
`ifdef INTERRUPT_CONTROLLER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_src, irq_mask;
  logic       irq_global_en, irq_ack, overrun_clr;
  logic       irq_en, irq_overrun;
  logic [1:0] irq_num;
  logic [3:0] irq_pending;

  int n_tests = 0;
  int n_fail  = 0;
  int sb[$];

  always #5 clk = ~clk;

  interrupt_controller #(.NUM_SRC(4), .NUM_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_src       (irq_src),
    .irq_mask      (irq_mask),
    .irq_global_en (irq_global_en),
    .irq_en        (irq_en),
    .irq_num       (irq_num),
    .irq_ack       (irq_ack),
    .irq_pending   (irq_pending),
    .irq_overrun   (irq_overrun),
    .overrun_clr   (overrun_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] v, input int n);
    irq_src = v;
    tick(n);
    irq_src = 4'b0;
  endtask

  task automatic wait_req(input string tag, input int max);
    int t = 0;
    while (!irq_en && t < max) begin
      tick();
      t++;
    end
    chk({tag, "_req"}, irq_en, 1);
  endtask

  task automatic sb_check(input string tag);
    int e;
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else begin
      e = sb.pop_front();
      chk(tag, irq_num, e);
    end
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq_src = '0; irq_mask = 4'hf; irq_global_en = 1'b1;
    irq_ack = 1'b0; overrun_clr = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_en", irq_en, 0);
    chk("rst_num", irq_num, 0);
    chk("rst_pend", irq_pending, 0);
    chk("rst_ovr", irq_overrun, 0);

    // Single source, exact request latency
    irq_src = 4'b0100;
    sb.push_back(2);
    for (int t = 1; t <= LAT + 1; t++) begin
      tick();
      if (t == LAT) chk("t1_early_en", irq_en, 0);
      if (t == 3) irq_src = 4'b0;
    end
    chk("t1_en", irq_en, 1);
    sb_check("t1_num");
    chk("t1_pend", irq_pending, 4'b0100);
    irq_src = 4'b0;
    ack_once();
    chk("t1_ack_en", irq_en, 0);
    chk("t1_ack_pend", irq_pending, 0);
    tick(3);
    chk("t1_idle_en", irq_en, 0);

    // Two sources together: priority and back-to-back spacing
    sb.push_back(1);
    sb.push_back(3);
    pulse(4'b1010, 3);
    wait_req("t2a", 10);
    sb_check("t2a_num");
    ack_once();
    chk("t2_gap_en", irq_en, 0);
    tick();
    chk("t2_idle_en", irq_en, 0);
    tick();
    chk("t2b_en", irq_en, 1);
    sb_check("t2b_num");
    ack_once();
    tick(2);
    chk("t2_pend", irq_pending, 0);

    // Masked source latches but is not presented until unmasked
    irq_mask = 4'b1110;
    pulse(4'b0001, 3);
    tick(3);
    chk("t3_pend", irq_pending, 4'b0001);
    chk("t3_masked_en", irq_en, 0);
    irq_mask = 4'hf;
    sb.push_back(0);
    tick();
    chk("t3_en", irq_en, 1);
    sb_check("t3_num");
    ack_once();
    tick(2);

    // Overrun: second edge while still pending yields one request
    sb.push_back(2);
    pulse(4'b0100, 2);
    tick(2);
    pulse(4'b0100, 2);
    tick(LAT + 1);
    chk("t4_ovr", irq_overrun, 1);
    wait_req("t4", 10);
    sb_check("t4_num");
    ack_once();
    tick(3);
    chk("t4_single_en", irq_en, 0);
    chk("t4_pend", irq_pending, 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("t4_ovr_clr", irq_overrun, 0);

    // Long ack clears only one source and holds in GAP
    sb.push_back(0);
    sb.push_back(1);
    pulse(4'b0011, 3);
    wait_req("t5a", 10);
    sb_check("t5a_num");
    irq_ack = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t5_gap_en", irq_en, 0);
    end
    chk("t5_pend", irq_pending, 4'b0010);
    irq_ack = 1'b0;
    tick();
    chk("t5_idle_en", irq_en, 0);
    tick();
    chk("t5b_en", irq_en, 1);
    sb_check("t5b_num");

    // Global enable withdrawal keeps pending
    irq_global_en = 1'b0;
    tick();
    chk("t6_wd_en", irq_en, 0);
    chk("t6_wd_pend", irq_pending, 4'b0010);
    irq_global_en = 1'b1;
    sb.push_back(1);
    wait_req("t6", 4);
    sb_check("t6_num");

    // Reset mid-handshake drops everything
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_en", irq_en, 0);
    chk("t7_num", irq_num, 0);
    chk("t7_pend", irq_pending, 0);
    chk("t7_ovr", irq_overrun, 0);
    tick(5);
    chk("t7_quiet_en", irq_en, 0);
    sb.push_back(3);
    pulse(4'b1000, 3);
    wait_req("t7", 10);
    sb_check("t7_num");
    ack_once();
    tick(2);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
